// File: rtl/rc_pulse_capture.sv
// ---------------------------------------------------------------------------
// rc_pulse_capture : measures RC receiver pulse widths, flags out-of-range
//                    pulses and reports loss of signal.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rc_pulse_capture #(
  parameter int MIN_WIDTH = 800,
  parameter int MAX_WIDTH = 2200,
  parameter int TIMEOUT   = 25000
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        pwm_i,
  output logic [11:0] width_o,
  output logic        valid_o,
  output logic        error_o,
  output logic        signal_lost_o
);

  localparam logic [11:0] MIN_W   = 12'(MIN_WIDTH);
  localparam logic [11:0] MAX_W   = 12'(MAX_WIDTH);
  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [14:0] TO_VAL  = 15'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, HIGH = 1'b1} state_t;

  state_t      state, state_next;
  logic        sync1, sync2, prev;
  logic [1:0]  fill;
  logic        armed;
  logic [11:0] width_cnt, width_cnt_next;
  logic [11:0] width_next;
  logic        valid_next, error_next;
  logic [14:0] timeout_cnt, timeout_cnt_next;
  logic        rise, fall;

  // A rise is only trusted once the pin has been seen low after reset, so a
  // pulse already in progress at reset release is never measured.
  assign rise = sync2 & ~prev & armed;
  assign fall = ~sync2 & prev;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      prev        <= 1'b0;
      fill        <= 2'b00;
      armed       <= 1'b0;
      state       <= IDLE;
      width_cnt   <= 12'd0;
      width_o     <= 12'd0;
      valid_o     <= 1'b0;
      error_o     <= 1'b0;
      timeout_cnt <= TO_VAL;
    end else begin
      sync1       <= pwm_i;
      sync2       <= sync1;
      prev        <= sync2;
      fill        <= {fill[0], 1'b1};
      armed       <= armed | (fill[1] & ~sync2);
      state       <= state_next;
      width_cnt   <= width_cnt_next;
      width_o     <= width_next;
      valid_o     <= valid_next;
      error_o     <= error_next;
      timeout_cnt <= timeout_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    width_cnt_next = width_cnt;
    width_next     = width_o;
    valid_next     = 1'b0;
    error_next     = 1'b0;
    if (!enable_i) begin
      state_next     = IDLE;
      width_cnt_next = 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next     = HIGH;
            width_cnt_next = 12'd1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = IDLE;
            if (width_cnt >= MIN_W && width_cnt <= MAX_W) begin
              valid_next = 1'b1;
              width_next = width_cnt;
            end else begin
              error_next = 1'b1;
            end
          end else if (width_cnt != CNT_MAX) begin
            width_cnt_next = width_cnt + 12'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Cleared together with the valid strobe so signal_lost drops that cycle.
    if (valid_next)
      timeout_cnt_next = 15'd0;
    else if (timeout_cnt == TO_VAL)
      timeout_cnt_next = timeout_cnt;
    else
      timeout_cnt_next = timeout_cnt + 15'd1;
  end

  assign signal_lost_o = (timeout_cnt == TO_VAL);

endmodule

`default_nettype wire

// File: doc/rc_pulse_capture.md
RC_PULSE_CAPTURE -- requirements
Module: rc_pulse_capture

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 800: shortest accepted pulse in clock cycles (800 us at 1 MHz).
REQ-002 SHALL have parameter MAX_WIDTH, default 2200: longest accepted pulse in clock cycles.
REQ-003 SHALL have parameter TIMEOUT, default 25000: cycles without an accepted pulse before signal loss; legal range 1..32767.
REQ-004 SHALL have port clock_i  input  1  the single clock, 1 MHz nominal.
REQ-005 SHALL have port reset_n_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable_i  input  1  capture enable, synchronous to clock_i.
REQ-007 SHALL have port pwm_i  input  1  raw RC receiver pulse, asynchronous to clock_i.
REQ-008 SHALL have port width_o  output  12  last accepted pulse width in cycles; feeds the downstream pwm_analyzer threshold stage.
REQ-009 SHALL have port valid_o  output  1  one-cycle strobe: width_o updated.
REQ-010 SHALL have port error_o  output  1  one-cycle strobe: completed pulse out of range.
REQ-011 SHALL have port signal_lost_o  output  1  level: no accepted pulse within TIMEOUT cycles.

Function
REQ-012 SHALL pass pwm_i through a two-flop synchronizer, then a third flop for edge detection; rise = sync high and prev low, fall = sync low and prev high.
REQ-013 SHALL implement FSM states IDLE and HIGH; IDLE -> HIGH on rise; HIGH -> IDLE on fall.
REQ-014 SHALL load the 12-bit width counter with 1 on the rise cycle and increment it every cycle in HIGH, saturating at 4095, never wrapping.
REQ-015 SHALL make a pin pulse high for exactly W clock periods yield a measured width of W.
REQ-016 SHALL, on fall in HIGH with MIN_WIDTH <= width <= MAX_WIDTH (inclusive), register width into width_o and assert valid_o for one cycle.
REQ-017 SHALL, on fall in HIGH with width outside that range, assert error_o for one cycle, leave width_o unchanged, and not assert valid_o.
REQ-018 SHALL register valid_o/error_o so they assert on the third rising clock_i edge after pwm_i falls (synchronizer latency 2 + 1 register).
REQ-019 SHALL ignore a fall seen in IDLE; a partial pulse present at reset release or enable assertion produces neither strobe.
REQ-020 SHALL keep valid_o and error_o mutually exclusive and never asserted in consecutive cycles from the same pulse.
REQ-021 SHALL keep a 15-bit timeout counter: cleared to 0 in the cycle valid_o asserts, else incremented per cycle saturating at TIMEOUT.
REQ-022 SHALL drive signal_lost_o = 1 exactly when timeout counter == TIMEOUT; error pulses do not clear it.
REQ-023 SHALL, while enable_i is low, force FSM to IDLE, clear width counter, suppress valid_o/error_o, hold width_o, and keep timeout counting.
REQ-024 SHALL treat enable_i deassertion mid-pulse as abort: no strobe for that pulse.

Reset
REQ-025 SHALL asynchronously on reset_n_i low set: FSM IDLE, synchronizer and edge flops 0, width counter 0, width_o 0, valid_o 0, error_o 0, timeout counter TIMEOUT, signal_lost_o 1.
REQ-026 SHALL resume capture on the first clock edge after reset_n_i deassertion, a rise being required before any measurement.

Verification
REQ-027 SHALL cover: reset with pwm_i high, release, pwm_i falls 500 cycles later -> no valid_o/error_o, signal_lost_o stays 1.
REQ-028 SHALL cover: enable_i=1, 1500-cycle pulse -> single valid_o on third edge after fall, width_o=1500, signal_lost_o 0 from that cycle.
REQ-029 SHALL cover boundaries: pulses 799, 800, 2200, 2201 -> error, valid(800), valid(2200), error; width_o stays 2200 after the 2201 pulse.
REQ-030 SHALL cover timeout: after valid_o, no pulses -> signal_lost_o rises exactly 25000 cycles later; next 1500 pulse clears it.
REQ-031 SHALL cover: pwm_i held high 5000 cycles then low -> error_o once, width counter saturates at 4095 only for >4095 cycles, no wrap, width_o unchanged.
REQ-032 SHALL cover: reset_n_i low mid-pulse (cycle 700 of 1500) -> all outputs at reset values immediately, no strobe on the following fall.
